prover_compute_w0_seq: RTL and testbench
========================================

PROVER_COMPUTE_W0_SEQ -- requirements
Module: prover_compute_w0_seq

Interface
REQ-001 The module SHALL have parameter ninbits, default 3, giving the number of w0 elements computed per invocation (legal range 1..64).
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rstb  input  1  reset, asynchronous, active-low.
REQ-004 Port en  input  1  start request, sampled only while ready=1.
REQ-005 Port w1  input  `F_NBITS x ninbits  per-element w1 operands; SHALL be held stable by the caller from the en cycle until ready rises.
REQ-006 Port w2_m_w1  input  `F_NBITS x ninbits  per-element (w2-w1) operands; same stability rule as w1.
REQ-007 Port tau  input  `F_NBITS  verifier challenge; captured on the accepted en.
REQ-008 Port ready  output  1  high when idle and w0 is valid.
REQ-009 Port ready_pulse  output  1  one-cycle strobe on each rising edge of ready.
REQ-010 Port w0  output  `F_NBITS x ninbits  result registers, w0[i] = w2_m_w1[i]*tau + w1[i] mod p.
REQ-011 Port ma_en  output  1  one-cycle issue strobe to the shared multiply-add unit.
REQ-012 Port ma_a, ma_b, ma_c  output  `F_NBITS each  operands a, b, c for a*b+c; they SHALL be w2_m_w1[idx], captured tau, and w1[idx].
REQ-013 Port ma_ready_pulse  input  1  multiply-add completion strobe.
REQ-014 Port ma_result  input  `F_NBITS  multiply-add result, valid when ma_ready_pulse=1.

Function
REQ-015 The block SHALL time-share one multiply-add unit across all ninbits elements, with at most one operation outstanding.
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-017 IDLE: ready=1; on en=1, capture tau, clear idx to 0, and go to ISSUE.
REQ-018 ISSUE: drive ma_en=1 for exactly one cycle with the operands for idx, then go to WAIT.
REQ-019 WAIT: on ma_ready_pulse=1, write ma_result into w0[idx]; if idx=ninbits-1 go to IDLE, else increment idx and go to ISSUE.
REQ-020 ma_ready_pulse asserted in IDLE or ISSUE SHALL be ignored, with no register change.
REQ-021 ma_a/ma_b/ma_c SHALL be valid while ma_en=1; their values at other times are don't-care.
REQ-022 ready SHALL be 0 from the cycle after the accepted en until the cycle after the final ma_ready_pulse; ready_pulse SHALL assert in that same cycle only.
REQ-023 Latency: with unit latency L (pulse L>=1 cycles after ma_en), ready SHALL rise exactly ninbits*(L+1)+1 cycles after the en cycle.
REQ-024 en while ready=0 SHALL be ignored; tau changes while busy SHALL not affect the operation in flight.
REQ-025 w0[i] SHALL hold its value until overwritten; elements not yet recomputed keep prior-run values while busy.
REQ-026 en in the same cycle that ready rises SHALL be accepted, i.e. back-to-back runs with no idle gap.
REQ-027 ninbits=1 SHALL work: one ISSUE/WAIT pair, with idx never incrementing.
REQ-028 The idx counter SHALL be $clog2(ninbits) bits (minimum 1) and SHALL never exceed ninbits-1.

Reset
REQ-029 On rstb=0, asynchronously: state=IDLE, idx=0, captured tau=0, all w0[i]=0, ma_en=0, and ready=1.
REQ-030 ready_pulse SHALL be 0 during reset and SHALL not fire on reset release (the internal delayed-ready register resets to 1).
REQ-031 Reset asserted mid-operation SHALL abort the run with no further ma_en; a late ma_ready_pulse after release SHALL be ignored.

Verification
REQ-032 Basic: ninbits=3, L=2, tau=2, w2_m_w1={3,5,7}, w1={1,1,1}, one en pulse -> w0={7,11,15}, ready rises at cycle 10, ready_pulse high for one cycle, exactly 3 ma_en pulses.
REQ-033 Variable latency: unit latencies {1,5,3} -> same w0 results, and ma_en never asserts while an operation is outstanding.
REQ-034 Busy en: en re-pulsed while busy with tau=9 -> ignored, results use tau=2, only 3 ma_en pulses.
REQ-035 Back-to-back: en held high through the ready-rise cycle -> second run starts immediately, ready_pulse high exactly once per run, idx restarts at 0.
REQ-036 Reset mid-run: rstb low during WAIT for idx=1 -> w0 all 0, ready=1, no ready_pulse; the stray pulse after release is ignored and a subsequent run is correct.
REQ-037 Spurious strobe: ma_ready_pulse in IDLE with ma_result=0x55 -> w0 unchanged, state unchanged.

Source files
------------

// File: rtl/prover_compute_w0_seq.sv
// ---------------------------------------------------------------------------
// prover_compute_w0_seq
//
// Computes w0[i] = w2_m_w1[i] * tau + w1[i] (mod p) for ninbits elements by
// time-sharing one external multiply-add unit. One operation is in flight at
// a time; each result lands in its own w0 register.
//
// Ports
//   clk            sole clock, rising edge
//   rstb           asynchronous active-low reset
//   en             start request, accepted only while ready=1
//   w1, w2_m_w1    per-element operands, held stable by caller while busy
//   tau            challenge, captured on the accepted en
//   ready          idle and w0 valid
//   ready_pulse    one-cycle strobe on each rising edge of ready
//   w0             result registers
//   ma_en          one-cycle issue strobe to the multiply-add unit
//   ma_a/ma_b/ma_c operands for a*b+c (w2_m_w1[idx], tau, w1[idx])
//   ma_ready_pulse multiply-add completion strobe
//   ma_result      multiply-add result, valid with ma_ready_pulse
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready=1, waiting for en
// ISSUE  | ma_en=1 for one cycle with operands of element idx
// WAIT   | waiting for ma_ready_pulse, then store into w0[idx]
// ---------------------------------------------------------------------------
`ifndef F_NBITS
`define F_NBITS 61
`endif

module prover_compute_w0_seq #(
  parameter int ninbits = 3
) (
  input  logic                               clk,
  input  logic                               rstb,
  input  logic                               en,
  input  logic [ninbits-1:0][`F_NBITS-1:0]   w1,
  input  logic [ninbits-1:0][`F_NBITS-1:0]   w2_m_w1,
  input  logic [`F_NBITS-1:0]                tau,
  output logic                               ready,
  output logic                               ready_pulse,
  output logic [ninbits-1:0][`F_NBITS-1:0]   w0,
  output logic                               ma_en,
  output logic [`F_NBITS-1:0]                ma_a,
  output logic [`F_NBITS-1:0]                ma_b,
  output logic [`F_NBITS-1:0]                ma_c,
  input  logic                               ma_ready_pulse,
  input  logic [`F_NBITS-1:0]                ma_result
);

  localparam int FW = `F_NBITS;
  localparam int IW = (ninbits > 1) ? $clog2(ninbits) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(ninbits - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [FW-1:0]                 tau_q, tau_d;
  logic [ninbits-1:0][FW-1:0]    w0_q;
  logic                          ready_dly_q;
  logic                          wr_en;

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tau_d   = tau_q;
    wr_en   = 1'b0;
    ma_en   = 1'b0;
    ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (en) begin
          tau_d   = tau;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ma_en   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion strobes outside WAIT fall through the default-hold path
        // and therefore change nothing.
        if (ma_ready_pulse) begin
          wr_en = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tau_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tau_q   <= tau_d;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      w0_q <= '0;
    end else if (wr_en) begin
      w0_q[idx_q] <= ma_result;
    end
  end

  // Delayed ready resets high so that leaving reset (where ready is already
  // 1) never looks like a rising edge.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ready_dly_q <= 1'b1;
    end else begin
      ready_dly_q <= ready;
    end
  end

  assign ready_pulse = ready & ~ready_dly_q;
  assign w0          = w0_q;

  // Operands only matter while ma_en is high; tau comes from the captured
  // copy so caller changes to tau while busy have no effect.
  assign ma_a = w2_m_w1[idx_q];
  assign ma_b = tau_q;
  assign ma_c = w1[idx_q];

endmodule

// File: tb/tb_prover_compute_w0_seq.sv
`ifndef F_NBITS
`define F_NBITS 61
`endif

module tb_prover_compute_w0_seq;

  localparam int N = 3;
  localparam int F = `F_NBITS;

  typedef logic [F-1:0]         fe_t;
  typedef logic [N-1:0][F-1:0]  vec_t;
  typedef logic [N-1:0][7:0]    lat_t;

  typedef struct {
    string name;
    fe_t   tau;
    vec_t  w1;
    vec_t  w2m;
    lat_t  lat;
    vec_t  exp_w0;
    int    exp_cyc;
  } vec_s;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic en = 1'b0;
  vec_t w1 = '0;
  vec_t w2_m_w1 = '0;
  fe_t  tau = '0;
  logic ready, ready_pulse, ma_en;
  vec_t w0;
  fe_t  ma_a, ma_b, ma_c;
  logic ma_ready_pulse = 1'b0;
  fe_t  ma_result = '0;

  always #5 clk = ~clk;

  prover_compute_w0_seq #(.ninbits(N)) dut (
    .clk            (clk),
    .rstb           (rstb),
    .en             (en),
    .w1             (w1),
    .w2_m_w1        (w2_m_w1),
    .tau            (tau),
    .ready          (ready),
    .ready_pulse    (ready_pulse),
    .w0             (w0),
    .ma_en          (ma_en),
    .ma_a           (ma_a),
    .ma_b           (ma_b),
    .ma_c           (ma_c),
    .ma_ready_pulse (ma_ready_pulse),
    .ma_result      (ma_result)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_ma = 0;
  int   n_rp = 0;
  bit   pend = 0;
  int   cnt = 0;
  fe_t  res = '0;
  lat_t lat_cur = '0;
  int   op_n = 0;
  bit   inj = 0;
  fe_t  inj_val = '0;
  logic prev_ready = 1'b1;
  vec_s tbl [5];

  function automatic vec_t mk3(input fe_t a, input fe_t b, input fe_t c);
    vec_t v;
    v[0] = a;
    v[1] = b;
    v[2] = c;
    return v;
  endfunction

  function automatic lat_t lat3(input int a, input int b, input int c);
    lat_t l;
    l[0] = 8'(a);
    l[1] = 8'(b);
    l[2] = 8'(c);
    return l;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_w0(input string name, input vec_t exp);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_w0[%0d]", name, i), 64'(w0[i]), 64'(exp[i]));
    end
  endtask

  // One clock: advance to the falling edge, then play the multiply-add unit.
  task automatic tick();
    @(negedge clk);
    cyc++;
    ma_ready_pulse = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        ma_ready_pulse = 1'b1;
        ma_result      = res;
        pend           = 0;
      end
    end
    if (inj) begin
      ma_ready_pulse = 1'b1;
      ma_result      = inj_val;
      inj            = 0;
    end
    if (ma_en) begin
      chk("no_overlap", 64'(pend), 64'(0));
      pend = 1;
      cnt  = int'(lat_cur[op_n % N]);
      op_n++;
      res  = ma_a * ma_b + ma_c;
      n_ma++;
    end
    if (ready_pulse) n_rp++;
    chk("ready_pulse_edge", 64'(ready_pulse), 64'(ready & ~prev_ready));
    prev_ready = ready;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < budget);
    chk("ready_rise_in_budget", 64'(ready), 64'(1));
  endtask

  task automatic load(input fe_t t, input vec_t a, input vec_t b, input lat_t l);
    tau     = t;
    w1      = a;
    w2_m_w1 = b;
    lat_cur = l;
    op_n    = 0;
  endtask

  initial begin
    int n, n2, ma0, rp0;

    tbl[0] = '{"basic",    fe_t'(2),  mk3(1, 1, 1), mk3(3, 5, 7), lat3(2, 2, 2),
               mk3(7, 11, 15), 10};
    tbl[1] = '{"var_lat",  fe_t'(2),  mk3(1, 1, 1), mk3(3, 5, 7), lat3(1, 5, 3),
               mk3(7, 11, 15), 13};
    tbl[2] = '{"tau_zero", fe_t'(0),  mk3(4, 5, 6), mk3(100, 200, 300), lat3(1, 1, 1),
               mk3(4, 5, 6), 7};
    tbl[3] = '{"tau_ten",  fe_t'(10), mk3(9, 8, 7), mk3(0, 1, 2), lat3(3, 1, 2),
               mk3(9, 18, 27), 10};
    tbl[4] = '{"wide",     fe_t'(64'd1 << 20),
               mk3(5, 0, fe_t'(64'd1 << 40)),
               mk3(fe_t'(64'd1 << 20), 3, 0), lat3(1, 2, 1),
               mk3(fe_t'((64'd1 << 40) + 5), fe_t'(64'd3 << 20), fe_t'(64'd1 << 40)), 8};

    // Reset state
    tick();
    tick();
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_ready_pulse", 64'(ready_pulse), 64'(0));
    chk("rst_ma_en", 64'(ma_en), 64'(0));
    chk_w0("rst", mk3(0, 0, 0));
    rstb = 1'b1;
    tick();
    tick();
    chk("no_pulse_on_release", 64'(n_rp), 64'(0));

    // Table-driven single runs
    for (int v = 0; v < 5; v++) begin
      load(tbl[v].tau, tbl[v].w1, tbl[v].w2m, tbl[v].lat);
      ma0 = n_ma;
      rp0 = n_rp;
      en  = 1'b1;
      tick();
      en  = 1'b0;
      chk({tbl[v].name, "_busy"}, 64'(ready), 64'(0));
      wait_ready(200, n);
      chk({tbl[v].name, "_latency"}, 64'(n + 1), 64'(tbl[v].exp_cyc));
      chk_w0(tbl[v].name, tbl[v].exp_w0);
      chk({tbl[v].name, "_ma_count"}, 64'(n_ma - ma0), 64'(3));
      tick();
      chk({tbl[v].name, "_rp_count"}, 64'(n_rp - rp0), 64'(1));
    end

    // en while busy with a different tau must be ignored
    load(2, mk3(1, 1, 1), mk3(3, 5, 7), lat3(2, 2, 2));
    ma0 = n_ma;
    rp0 = n_rp;
    en  = 1'b1;
    tick();
    en  = 1'b0;
    chk("busy_hold_old_w0", 64'(w0[2]), 64'(1) << 40);
    tau = 9;
    en  = 1'b1;
    tick();
    tick();
    en  = 1'b0;
    wait_ready(200, n);
    chk("busy_latency", 64'(n + 3), 64'(10));
    chk_w0("busy", mk3(7, 11, 15));
    chk("busy_ma_count", 64'(n_ma - ma0), 64'(3));
    chk("busy_rp_count", 64'(n_rp - rp0), 64'(1));
    tick();

    // Back-to-back: en held through the ready-rise cycle
    load(3, mk3(0, 0, 0), mk3(1, 2, 3), lat3(1, 1, 1));
    ma0 = n_ma;
    rp0 = n_rp;
    en  = 1'b1;
    tick();
    wait_ready(200, n);
    chk("b2b_first_latency", 64'(n + 1), 64'(7));
    chk_w0("b2b_first", mk3(3, 6, 9));
    load(2, mk3(1, 1, 1), mk3(3, 5, 7), lat3(1, 1, 1));
    tick();
    en = 1'b0;
    chk("b2b_restart", 64'(ready), 64'(0));
    wait_ready(200, n2);
    chk("b2b_second_latency", 64'(n2 + 1), 64'(7));
    chk_w0("b2b_second", mk3(7, 11, 15));
    chk("b2b_ma_count", 64'(n_ma - ma0), 64'(6));
    chk("b2b_rp_count", 64'(n_rp - rp0), 64'(2));
    tick();

    // Reset during WAIT for idx=1, then a stray completion after release
    load(2, mk3(1, 1, 1), mk3(3, 5, 7), lat3(2, 2, 2));
    ma0 = n_ma;
    rp0 = n_rp;
    en  = 1'b1;
    tick();
    en  = 1'b0;
    repeat (4) tick();
    chk("rstmid_ops_issued", 64'(n_ma - ma0), 64'(2));
    rstb = 1'b0;
    #1;
    chk("rstmid_ready", 64'(ready), 64'(1));
    chk("rstmid_ready_pulse", 64'(ready_pulse), 64'(0));
    chk("rstmid_ma_en", 64'(ma_en), 64'(0));
    chk_w0("rstmid", mk3(0, 0, 0));
    pend       = 0;
    prev_ready = 1'b1;
    tick();
    tick();
    rstb = 1'b1;
    tick();
    inj     = 1;
    inj_val = 'h77;
    tick();
    tick();
    tick();
    chk_w0("rstmid_stray", mk3(0, 0, 0));
    chk("rstmid_stray_ready", 64'(ready), 64'(1));
    chk("rstmid_no_more_ma", 64'(n_ma - ma0), 64'(2));
    chk("rstmid_no_rp", 64'(n_rp - rp0), 64'(0));
    load(2, mk3(1, 1, 1), mk3(3, 5, 7), lat3(2, 2, 2));
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_ready(200, n);
    chk("rstmid_rerun_latency", 64'(n + 1), 64'(10));
    chk_w0("rstmid_rerun", mk3(7, 11, 15));
    tick();

    // Spurious completion strobe while idle
    ma0     = n_ma;
    rp0     = n_rp;
    inj     = 1;
    inj_val = 'h55;
    tick();
    tick();
    tick();
    chk_w0("spurious", mk3(7, 11, 15));
    chk("spurious_ready", 64'(ready), 64'(1));
    chk("spurious_ma_count", 64'(n_ma - ma0), 64'(0));
    chk("spurious_rp_count", 64'(n_rp - rp0), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
